// File: rtl/stim_sequencer.sv
// Sweeps a 4-bit stimulus vector through all 16 values and records the response of a downstream function.
// Optional macro STIM_CAPTURE_EN enables the truth_table capture; without it truth_table is tied to zero.
module stim_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        f,
  output logic        w0,
  output logic        w1,
  output logic        w2,
  output logic        w3,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table
);

  // state  | meaning
  // IDLE   | waiting for start, stimulus forced to 0
  // DRIVE  | presenting vector index for HOLD_CYCLES cycles
  // SAMPLE | one cycle, f captured into truth_table[index] at its end
  // DONE   | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] index, index_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic       presenting;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      index    <= 4'd0;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      index    <= index_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    index_nxt    = index;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt    = DRIVE;
          index_nxt    = 4'd0;
          hold_cnt_nxt = 8'd0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = SAMPLE;
        end else begin
          hold_cnt_nxt = hold_cnt + 8'd1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (index == 4'd15) begin
          state_nxt = DONE;
        end else begin
          state_nxt    = DRIVE;
          index_nxt    = index + 4'd1;
          hold_cnt_nxt = 8'd0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // An abort seen during DONE also suppresses that cycle's done pulse.
  assign presenting       = (state == DRIVE) || (state == SAMPLE);
  assign busy             = (state != IDLE);
  assign done             = (state == DONE) && !abort;
  assign {w3, w2, w1, w0} = presenting ? index : 4'd0;

`ifdef STIM_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      truth_table <= 16'h0000;
    end else if ((state == SAMPLE) && !abort) begin
      truth_table[index] <= f;
    end
  end
`else
  logic unused_f;
  assign unused_f    = f;
  assign truth_table = 16'h0000;
`endif

endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, number of DRIVE cycles each input vector is held before the sample cycle; legal range 1..255.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port start  input  1  request to run one full 16-vector sweep; sampled only in IDLE.
REQ-005 Port abort  input  1  terminates a running sweep.
REQ-006 Port f  input  1  response of the downstream 4-input function under test.
REQ-007 Ports w0, w1, w2, w3  output  1 each  stimulus vector to the downstream function; w3 is the MSB of the vector index.
REQ-008 Port busy  output  1  high in every state except IDLE.
REQ-009 Port done  output  1  one-cycle pulse when a sweep completes without abort.
REQ-010 Port truth_table  output  16  captured response; bit k holds f observed for index k.

Function
REQ-011 The block SHALL implement the states IDLE, DRIVE, SAMPLE and DONE.
REQ-012 In IDLE, with start=1 and abort=0, the block SHALL enter DRIVE on the next edge with index=0 and hold_cnt=0.
REQ-013 In DRIVE and SAMPLE, {w3,w2,w1,w0} SHALL equal index and remain stable for the whole presentation.
REQ-014 DRIVE SHALL last exactly HOLD_CYCLES cycles, after which the block SHALL enter SAMPLE for exactly one cycle.
REQ-015 At the edge ending SAMPLE, the block SHALL write truth_table[index] with f and leave all other bits unchanged.
REQ-016 From SAMPLE, if index=15 the block SHALL go to DONE; otherwise it SHALL increment index by 1 and return to DRIVE with hold_cnt=0.
REQ-017 The 4-bit index SHALL never wrap: 15 is terminal.
REQ-018 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-019 Vector k SHALL occupy cycles k*(HOLD_CYCLES+1)+1 .. (k+1)*(HOLD_CYCLES+1) after the start edge, and done SHALL be high in cycle 16*(HOLD_CYCLES+1)+1.
REQ-020 In IDLE and DONE, w0..w3 SHALL be 0.
REQ-021 start SHALL be ignored in every state except IDLE, including DONE.
REQ-022 When abort=1 in DRIVE, SAMPLE or DONE, the block SHALL enter IDLE on the next edge with no done pulse and no capture that cycle.
REQ-023 Bits of truth_table already written before an abort SHALL be retained.
REQ-024 When start=1 and abort=1 arrive together in IDLE, abort SHALL win and the block SHALL stay in IDLE.
REQ-025 truth_table SHALL hold its value from the end of a sweep until the next sweep overwrites it.
REQ-026 A new sweep SHALL NOT clear truth_table at start; each bit is overwritten as it is sampled.

Reset
REQ-027 While rst=1, the block SHALL immediately, without waiting for a clock edge, enter IDLE and set index=0, hold_cnt=0, w0..w3=0, busy=0, done=0 and truth_table=16'h0000.
REQ-028 A reset asserted mid-sweep SHALL discard the sweep with no done pulse.
REQ-029 The first start SHALL be honoured on the first rising edge after rst deasserts.

Configuration
REQ-030 With macro STIM_CAPTURE_EN defined, the capture logic of REQ-015 SHALL be present.
REQ-031 Without STIM_CAPTURE_EN, truth_table SHALL be driven constant 16'h0000, f SHALL be ignored, and sequencing, timing and done SHALL be unchanged.

Verification
REQ-032 HOLD_CYCLES=4, f=w0^w1^w2^w3, pulse start -> vector k presented in cycles 5k+1..5k+5, done in cycle 81, truth_table=16'h6996.
REQ-033 f=w3&w2&w1&w0 -> truth_table=16'h8000; repeat the sweep with f=w0|w1|w2|w3 -> truth_table=16'hFFFE.
REQ-034 Assert abort while index=6 in DRIVE -> IDLE next cycle, w=0000, no done, truth_table bits 0..5 updated and bits 6..15 unchanged.
REQ-035 Hold start high for the entire sweep -> exactly one sweep and one done pulse; with start still high in the cycle after done, the next sweep begins from IDLE.
REQ-036 Assert rst asynchronously at index=9 -> outputs 0 without waiting for a clock edge, truth_table=0, no done.
REQ-037 Build without STIM_CAPTURE_EN and run REQ-032 stimulus -> truth_table=16'h0000, done still in cycle 81.
